// File: rtl/i2c_rx_deser.sv
// I2C receive deserializer: shifts sampled SDA bits MSB-first into one of two
// frame buffers and hands completed frames to the host through valid/ready.
module i2c_rx_deser #(
    parameter int MAX_BYTES = 4,
    parameter int DATA_W    = 8*MAX_BYTES,
    parameter int CNT_W     = $clog2(8*MAX_BYTES+1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx_start,
    input  logic [$clog2(MAX_BYTES+1)-1:0] rx_size,
    input  logic                           rx_bit_vld,
    input  logic                           rx_bit,
    input  logic                           rx_abort,
    input  logic                           ovr_clr,
    output logic [DATA_W-1:0]              rx_data,
    output logic [$clog2(MAX_BYTES+1)-1:0] rx_bytes,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic                           byte_done,
    output logic                           busy,
    output logic                           overrun,
    output logic [1:0]                     dbg_state
);

    localparam int SZ_W = $clog2(MAX_BYTES+1);
    localparam logic [SZ_W-1:0] MAX_SZ = SZ_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_data  [2];
    logic [SZ_W-1:0]   r_bytes [2];
    logic [1:0]        r_full;
    logic              r_wp, r_rp;
    logic [SZ_W-1:0]   r_size;
    logic [CNT_W-1:0]  r_bitcnt;
    logic              r_byte_done;
    logic              r_overrun;

    logic              w_pop;
    logic              w_wp_free;
    logic [SZ_W-1:0]   w_size;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [CNT_W-1:0]  w_target;
    logic              w_start_ok, w_drop, w_shift, w_count, w_complete;

    // Handshake: a frame transfers on any cycle where rx_valid && rx_ready;
    // rx_valid never drops and rx_data never changes until that transfer.
    assign rx_valid  = r_full[r_rp];
    assign rx_data   = r_data[r_rp];
    assign rx_bytes  = r_bytes[r_rp];
    assign w_pop     = rx_valid && rx_ready;
    // A same-cycle pop of the write buffer frees it for this cycle's start.
    assign w_wp_free = !r_full[r_wp] || (w_pop && (r_rp == r_wp));
    assign w_size    = ((rx_size == '0) || (rx_size > MAX_SZ)) ? MAX_SZ : rx_size;
    assign w_cnt_inc = r_bitcnt + CNT_W'(1);
    assign w_target  = CNT_W'(r_size) << 3;

    assign byte_done = r_byte_done;
    assign busy      = (r_state == S_RECV);
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_drop      = 1'b0;
        w_shift     = 1'b0;
        w_count     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE, S_DROP: begin
                if (rx_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (rx_start) begin
                    if (w_wp_free) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_RECV;
                    end else begin
                        w_drop      = 1'b1;
                        w_state_nxt = S_DROP;
                    end
                end else if ((r_state == S_DROP) && rx_bit_vld) begin
                    w_count = 1'b1;
                    if (w_cnt_inc == w_target) w_state_nxt = S_IDLE;
                end
            end
            S_RECV: begin
                if (rx_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (rx_start) begin
                    // buf[wp] is always empty while receiving, so restart in place
                    w_start_ok = 1'b1;
                end else if (rx_bit_vld) begin
                    w_shift = 1'b1;
                    if (w_cnt_inc == w_target) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data[0]   <= '0;
            r_data[1]   <= '0;
            r_bytes[0]  <= '0;
            r_bytes[1]  <= '0;
            r_full      <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_size      <= '0;
            r_bitcnt    <= '0;
            r_byte_done <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_full[r_rp] <= 1'b0;
                r_rp         <= ~r_rp;
            end
            if (w_start_ok || w_drop) begin
                r_size   <= w_size;
                r_bitcnt <= '0;
            end
            if (w_start_ok) r_data[r_wp] <= '0;
            if (w_shift) begin
                r_data[r_wp] <= {r_data[r_wp][DATA_W-2:0], rx_bit};
                r_bitcnt     <= w_cnt_inc;
            end
            if (w_count) r_bitcnt <= w_cnt_inc;
            if (w_complete) begin
                r_full[r_wp]  <= 1'b1;
                r_bytes[r_wp] <= r_size;
                r_wp          <= ~r_wp;
            end
            r_byte_done <= w_shift && (w_cnt_inc[2:0] == 3'd0);
            if (w_drop)       r_overrun <= 1'b1;
            else if (ovr_clr) r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_rx_deser.sv
// Bench for i2c_rx_deser: directed scenarios followed by random frames, pops,
// aborts and flag clears, checked against a two-deep frame queue model.
module tb_i2c_rx_deser;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_start, rx_bit_vld, rx_bit, rx_abort, ovr_clr, rx_ready;
    logic [2:0]    rx_size;
    logic [DW-1:0] rx_data;
    logic [2:0]    rx_bytes;
    logic          rx_valid, byte_done, busy, overrun;
    logic [1:0]    dbg_state;

    logic [DW-1:0] exp_q[$];
    logic [2:0]    exp_b_q[$];
    bit            ovr_model;
    int            n_checks = 0;
    int            n_err    = 0;
    int            bd_cnt   = 0;

    i2c_rx_deser #(.MAX_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx_start(rx_start), .rx_size(rx_size),
        .rx_bit_vld(rx_bit_vld), .rx_bit(rx_bit), .rx_abort(rx_abort),
        .ovr_clr(ovr_clr), .rx_data(rx_data), .rx_bytes(rx_bytes),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .byte_done(byte_done),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (byte_done === 1'b1) bd_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_frame();
        chk("valid_before_pop", rx_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("pop_data", rx_data, exp_q[0]);
            chk("pop_bytes", rx_bytes, exp_b_q[0]);
            void'(exp_q.pop_front());
            void'(exp_b_q.pop_front());
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("valid_after_pop", rx_valid, exp_q.size() > 0);
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        ovr_model = 1'b0;
        chk("overrun_clr", overrun, 1'b0);
    endtask

    // Frame-level model: accepted when fewer than two frames are waiting
    // (after an optional pop in the start cycle); delivered only if all
    // 8*size bits arrive without an abort.
    task automatic send_frame(input int szf, input logic [DW-1:0] val, input int nbits,
                              input bit do_abort, input bit with_pop);
        int            eff;
        bit            acc;
        int            bd0;
        logic [DW-1:0] mask;
        logic [DW-1:0] shifted;
        eff  = (szf == 0 || szf > 4) ? 4 : szf;
        mask = (eff == 4) ? '1 : ((DW'(1) << (8*eff)) - DW'(1));
        if (with_pop) begin
            chk("start_pop_data", rx_data, exp_q[0]);
            rx_ready = 1'b1;
        end
        rx_size  = 3'(szf);
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        rx_ready = 1'b0;
        if (with_pop) begin
            void'(exp_q.pop_front());
            void'(exp_b_q.pop_front());
        end
        acc = (exp_q.size() < 2);
        if (!acc) ovr_model = 1'b1;
        chk("busy_start", busy, acc);
        chk("overrun_start", overrun, ovr_model);
        bd0 = bd_cnt;
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            shifted    = val >> (8*eff - 1 - i);
            rx_bit     = shifted[0];
            rx_bit_vld = 1'b1;
            tick();
            rx_bit_vld = 1'b0;
        end
        if (do_abort) begin
            rx_abort = 1'b1;
            tick();
            rx_abort = 1'b0;
        end
        tick();
        chk("byte_done_count", DW'(bd_cnt - bd0), DW'(acc ? nbits / 8 : 0));
        if (acc && !do_abort && nbits == 8*eff) begin
            exp_q.push_back(val & mask);
            exp_b_q.push_back(3'(eff));
        end
        chk("busy_end", busy, 1'b0);
        chk("valid_end", rx_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) chk("front_data", rx_data, exp_q[0]);
    endtask

    initial begin
        rst_n = 1'b0; rx_start = 1'b0; rx_size = '0; rx_bit_vld = 1'b0; rx_bit = 1'b0;
        rx_abort = 1'b0; ovr_clr = 1'b0; rx_ready = 1'b0; ovr_model = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", rx_data, '0);
        chk("rst_bytes", rx_bytes, '0);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_byte_done", byte_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        tick();

        send_frame(2, 32'h0000A5C3, 16, 0, 0);
        pop_frame();
        send_frame(0, 32'hDEADBEEF, 32, 0, 0);
        pop_frame();

        send_frame(1, 32'h11, 8, 0, 0);
        send_frame(1, 32'h22, 8, 0, 0);
        send_frame(1, 32'h33, 8, 0, 0);
        chk("overrun_set", overrun, 1'b1);
        pop_frame();
        pop_frame();
        clear_ovr();

        send_frame(1, 32'h7E, 5, 1, 0);
        send_frame(1, 32'h7E, 8, 0, 0);
        pop_frame();
        pop_frame();

        send_frame(1, 32'hA1, 8, 0, 0);
        send_frame(1, 32'hB2, 8, 0, 0);
        send_frame(1, 32'hC3, 8, 0, 1);
        chk("overrun_simul", overrun, 1'b0);
        pop_frame();
        pop_frame();

        send_frame(3, 32'h00123456, 24, 0, 0);
        rx_size = 3'd2; rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rx_bit = i[0]; rx_bit_vld = 1'b1;
            tick();
        end
        rx_bit_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", rx_data, '0);
        chk("arst_bytes", rx_bytes, '0);
        chk("arst_valid", rx_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_overrun", overrun, 1'b0);
        chk("arst_byte_done", byte_done, 1'b0);
        exp_q.delete();
        exp_b_q.delete();
        ovr_model = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(2, 32'h0000BEEF, 16, 0, 0);
        pop_frame();

        for (int it = 0; it < 150; it++) begin
            int op;
            int sz;
            int eff;
            op  = $urandom_range(0, 9);
            sz  = $urandom_range(0, 7);
            eff = (sz == 0 || sz > 4) ? 4 : sz;
            case (op)
                0, 1, 2, 3, 4: send_frame(sz, $urandom, 8*eff, 0, 0);
                5, 6:          pop_frame();
                7:             send_frame(sz, $urandom, $urandom_range(0, 8*eff - 1), 1, 0);
                8:             clear_ovr();
                default:       repeat ($urandom_range(1, 4)) tick();
            endcase
            chk("rand_overrun", overrun, ovr_model);
            chk("rand_valid", rx_valid, exp_q.size() > 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_rx_deser.md
# i2c_rx_deser

Parametrised I2C receive deserializer with ping-pong buffering. It assembles a serial frame of 1..MAX_BYTES bytes, MSB first, from the bit-level I2C receive sequencer. Completed frames are presented to the register/host side through a valid/ready handshake. Two frame buffers let reception continue while the previous frame waits to be consumed; a frame arriving with both buffers full is dropped and flagged.

## Interface
- MAX_BYTES, 4: maximum frame length in bytes (1..16).
- DATA_W, 8*MAX_BYTES: width of the frame data output (derived; never overridden).
- CNT_W, $clog2(8*MAX_BYTES+1): width of the bit counter.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- rx_start  in  1  one-cycle pulse that starts a frame and latches rx_size.
- rx_size  in  $clog2(MAX_BYTES+1)  frame length in bytes; 0 or >MAX_BYTES is clamped to MAX_BYTES.
- rx_bit_vld  in  1  one-cycle strobe: rx_bit is a sampled SDA bit.
- rx_bit  in  1  serial data bit.
- rx_abort  in  1  discards the frame in progress.
- ovr_clr  in  1  clears the sticky overrun flag.
- rx_data  out  DATA_W  oldest completed frame, right-justified; bits above 8*size are 0.
- rx_bytes  out  $clog2(MAX_BYTES+1)  clamped byte count of the frame on rx_data.
- rx_valid  out  1  rx_data/rx_bytes hold a completed frame.
- rx_ready  in  1  consumer accepts the frame when rx_valid && rx_ready.
- byte_done  out  1  one-cycle pulse after every 8th accepted bit.
- busy  out  1  a frame is being received (RECV state).
- overrun  out  1  sticky flag: a frame was dropped because no buffer was free.

## Operation
- Storage: two buffers (buf0, buf1), each holding DATA_W data bits, a byte count and a full flag. A write pointer (wp) and a read pointer (rp) each toggle 0/1.
- IDLE: on rx_start, if buf[wp] is empty after this cycle's pop, clear buf[wp], latch the clamped size, clear bitcnt and go to RECV. Otherwise set overrun and go to DROP.
- RECV: each rx_bit_vld does buf[wp].data <= {data[DATA_W-2:0], rx_bit} and increments bitcnt. The first bit received ends up at bit 8*size-1.
  - byte_done pulses the cycle after bitcnt reaches a multiple of 8.
  - When bitcnt reaches 8*size: set buf[wp].full, store its byte count, toggle wp and go to IDLE.
- DROP: ignore rx_bit_vld. Return to IDLE on the bit that would complete the frame, on rx_abort, or on rx_start (which is then re-evaluated as in IDLE).
- rx_abort in RECV: discard the partial data, leave buf[wp] empty and go to IDLE.
- rx_start in RECV: treat as an abort of the current frame and start a new frame in the same buffer.
- Output side:
  - rx_valid = buf[rp].full; rx_data and rx_bytes come from buf[rp].
  - A pop (rx_valid && rx_ready) clears buf[rp].full and toggles rp.
  - rx_data is stable while rx_valid && !rx_ready.
- overrun is set on a drop and cleared by ovr_clr. If both happen in the same cycle, set wins.
- Priority within a cycle: reset > rx_abort > rx_start > rx_bit_vld.

## Timing
- Reset values:
  - rx_data = 0, rx_bytes = 0, rx_valid = 0, byte_done = 0, busy = 0, overrun = 0.
  - Both buffers empty, wp = rp = 0, state IDLE.
- rx_start to busy: busy is high from the next edge.
- Last bit to rx_valid: rx_valid rises at the edge that samples the last bit. This holds when buf[rp] was empty, i.e. zero added latency.
- Throughput: a pop frees a buffer combinationally for the same cycle's start decision, so back-to-back frames with rx_ready held high never overrun.
- Completion and pop in the same cycle: both take effect; the pointers stay consistent.
- Reset asserted mid-frame: all state returns to reset values immediately; the partial frame is lost.
- bitcnt never exceeds 8*MAX_BYTES. Bits after completion, outside RECV, are ignored.

## Test plan
- MAX_BYTES=4: start with size=2, send 16 bits 0xA5C3 MSB first → byte_done pulses twice; rx_valid=1, rx_data=0x0000A5C3, rx_bytes=2.
- rx_size=0 with 32 bits 0xDEADBEEF → rx_bytes=4, rx_data=0xDEADBEEF.
- Hold rx_ready=0 and send frames 0x11, 0x22, 0x33 (size=1) → first two are retained in order; the third sets overrun, busy stays 0. Pop twice → 0x11 then 0x22. ovr_clr → overrun=0.
- Abort after 5 bits of size=1, then send a full frame 0x7E → only 0x7E is delivered; no stale bits.
- rx_start while both buffers are full, with a pop in the same cycle → the frame is accepted and overrun stays 0.
- Assert rst_n=0 after 12 bits of a size-2 frame → all outputs are 0 asynchronously; a following frame 0xBEEF is received correctly.
